// File: rtl/block_memory_pkg.sv
// Shared constants for the block_memory responder: FSM encodings and the
// width of the latency down-counter.
package block_memory_pkg;

  localparam int STATE_W = 3;
  localparam int CNT_W   = 4;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RD_WAIT = 3'd1;
  localparam logic [2:0] ST_RD_RESP = 3'd2;
  localparam logic [2:0] ST_WR_WAIT = 3'd3;
  localparam logic [2:0] ST_WR_DONE = 3'd4;

  // Counter preload so the response lands exactly `lat` edges after acceptance.
  function automatic logic [CNT_W-1:0] latency_load(input int unsigned lat);
    return CNT_W'(lat - 1);
  endfunction

endpackage

// File: rtl/mem_latency_counter.sv
// Loadable down-counter with a zero flag, used to model fixed memory latency.
module mem_latency_counter
  import block_memory_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic [CNT_W-1:0] o_count,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_count;

  // Load has priority; decrement saturates at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_count = r_count;
  assign o_zero  = (r_count == '0);

endmodule

// File: rtl/block_memory.sv
// Latency-modelled main memory answering cache readM/writeM requests with
// one-cycle input_readyM/doneM pulses; also counts serviced operations.
module block_memory
  import block_memory_pkg::*;
#(
  parameter int    WORD_SIZE   = 16,
  parameter int    READ_SIZE   = 4 * WORD_SIZE,
  parameter int    ADDR_BITS   = 8,
  parameter int    LATENCY     = 4,
  parameter int    WRITE_BLOCK = 1,
  parameter string INIT_FILE   = ""
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 readM,
  input  logic                 writeM,
  input  logic [WORD_SIZE-1:0] address,
  inout  wire  [READ_SIZE-1:0] dataM,
  output logic                 input_readyM,
  output logic                 doneM,
  output logic                 busy,
  output logic [WORD_SIZE-1:0] num_reads,
  output logic [WORD_SIZE-1:0] num_writes,
  output logic [STATE_W-1:0]   o_dbg_state
);

  localparam int WORDS_PER_BLOCK = READ_SIZE / WORD_SIZE;
  localparam int DEPTH           = 2 ** ADDR_BITS;
  localparam bit HAS_INIT_FILE   = (INIT_FILE != "");

  logic [STATE_W-1:0]   r_state;
  logic [ADDR_BITS-1:0] r_addr;
  logic [READ_SIZE-1:0] r_rd_data;
  logic [WORD_SIZE-1:0] r_num_reads;
  logic [WORD_SIZE-1:0] r_num_writes;
  logic [WORD_SIZE-1:0] r_mem [DEPTH];

  logic                 w_idle;
  logic                 w_load;
  logic                 w_dec;
  logic                 w_zero;
  logic [CNT_W-1:0]     w_count;
  logic                 w_commit;
  logic [READ_SIZE-1:0] w_block_rd;

  assign w_idle   = (r_state == ST_IDLE);
  assign w_load   = w_idle && (readM || writeM);
  assign w_dec    = (r_state == ST_RD_WAIT) || (r_state == ST_WR_WAIT);
  assign w_commit = (r_state == ST_WR_WAIT) && w_zero && !reset;

  mem_latency_counter u_lat_cnt (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_load),
    .i_load_val (latency_load(LATENCY)),
    .i_dec      (w_dec),
    .o_count    (w_count),
    .o_zero     (w_zero)
  );

  // Read wins a tie; a still-pending write is picked up after the idle cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_num_reads  <= '0;
      r_num_writes <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (readM) begin
            r_state <= ST_RD_WAIT;
          end else if (writeM) begin
            r_state <= ST_WR_WAIT;
          end
        end
        ST_RD_WAIT: begin
          if (w_zero) r_state <= ST_RD_RESP;
        end
        ST_RD_RESP: begin
          r_state     <= ST_IDLE;
          r_num_reads <= r_num_reads + 1'b1;
        end
        ST_WR_WAIT: begin
          if (w_zero) r_state <= ST_WR_DONE;
        end
        ST_WR_DONE: begin
          r_state      <= ST_IDLE;
          r_num_writes <= r_num_writes + 1'b1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_load) begin
      r_addr <= address[ADDR_BITS-1:0];
    end
    if ((r_state == ST_RD_WAIT) && w_zero) begin
      r_rd_data <= w_block_rd;
    end
  end

  always_comb begin
    w_block_rd = '0;
    for (int i = 0; i < WORDS_PER_BLOCK; i++) begin
      w_block_rd[i*WORD_SIZE +: WORD_SIZE] = r_mem[{r_addr[ADDR_BITS-1:2], 2'(i)}];
    end
  end

  // Storage has no reset: contents survive a reset pulse.
  generate
    if (WRITE_BLOCK != 0) begin : g_wr_block
      always_ff @(posedge clk) begin
        if (w_commit) begin
          for (int i = 0; i < WORDS_PER_BLOCK; i++) begin
            r_mem[{r_addr[ADDR_BITS-1:2], 2'(i)}] <= dataM[i*WORD_SIZE +: WORD_SIZE];
          end
        end
      end
    end else begin : g_wr_word
      always_ff @(posedge clk) begin
        if (w_commit) begin
          r_mem[r_addr] <= dataM[WORD_SIZE-1:0];
        end
      end
    end
  endgenerate

  assign dataM        = (r_state == ST_RD_RESP) ? r_rd_data : {READ_SIZE{1'bz}};
  assign input_readyM = (r_state == ST_RD_RESP);
  assign doneM        = (r_state == ST_WR_DONE);
  assign busy         = !w_idle;
  assign num_reads    = r_num_reads;
  assign num_writes   = r_num_writes;
  assign o_dbg_state  = r_state;

  logic w_unused;
  assign w_unused = &{1'b0, address[WORD_SIZE-1:ADDR_BITS], w_count, HAS_INIT_FILE,
                      dataM[READ_SIZE-1:WORD_SIZE]};

endmodule

// File: tb/tb_block_memory.sv
// Bench for block_memory: DUT 0 is block-write with LATENCY=4, DUT 1 is
// word-write with LATENCY=1; both are compared against an array-based model.
module tb_block_memory;

  logic        clk;
  logic        reset;
  logic [1:0]  rd, wr, drv_en;
  logic [1:0]  rdy, done, busy;
  logic [15:0] adr [2];
  logic [63:0] drv [2];
  logic [15:0] nrd [2];
  logic [15:0] nwr [2];
  logic [2:0]  dbg [2];
  wire  [63:0] dm0, dm1;

  assign dm0 = drv_en[0] ? drv[0] : 64'hz;
  assign dm1 = drv_en[1] ? drv[1] : 64'hz;

  block_memory #(.LATENCY(4), .WRITE_BLOCK(1)) u_dut0 (
    .clk(clk), .reset(reset), .readM(rd[0]), .writeM(wr[0]), .address(adr[0]),
    .dataM(dm0), .input_readyM(rdy[0]), .doneM(done[0]), .busy(busy[0]),
    .num_reads(nrd[0]), .num_writes(nwr[0]), .o_dbg_state(dbg[0])
  );

  block_memory #(.LATENCY(1), .WRITE_BLOCK(0)) u_dut1 (
    .clk(clk), .reset(reset), .readM(rd[1]), .writeM(wr[1]), .address(adr[1]),
    .dataM(dm1), .input_readyM(rdy[1]), .doneM(done[1]), .busy(busy[1]),
    .num_reads(nrd[1]), .num_writes(nwr[1]), .o_dbg_state(dbg[1])
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] mem_ref [2][256];
  int          exp_reads [2];
  int          exp_writes [2];
  logic [63:0] exp_q [$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int lat(input int d);
    return (d == 0) ? 4 : 1;
  endfunction

  function automatic logic [63:0] get_dm(input int d);
    return (d == 0) ? dm0 : dm1;
  endfunction

  function automatic logic [63:0] model_block(input int d, input logic [15:0] a);
    logic [63:0] r;
    int base;
    base = (int'(a) % 256) / 4 * 4;
    for (int i = 0; i < 4; i++) r[16*i +: 16] = mem_ref[d][base + i];
    return r;
  endfunction

  function automatic void model_write(input int d, input logic [15:0] a, input logic [63:0] data);
    int base;
    if (d == 0) begin
      base = (int'(a) % 256) / 4 * 4;
      for (int i = 0; i < 4; i++) mem_ref[0][base + i] = data[16*i +: 16];
    end else begin
      mem_ref[1][int'(a) % 256] = data[15:0];
    end
  endfunction

  task automatic check_idle_counts(input int d, input string tag);
    check_eq($sformatf("%s d%0d idle busy", tag, d), 64'(busy[d]), 64'd0);
    check_eq($sformatf("%s d%0d num_reads", tag, d), 64'(nrd[d]), 64'(16'(exp_reads[d])));
    check_eq($sformatf("%s d%0d num_writes", tag, d), 64'(nwr[d]), 64'(16'(exp_writes[d])));
  endtask

  // driver: called at a negedge with the DUT idle; returns at the idle-gap negedge
  task automatic do_write(input int d, input logic [15:0] a, input logic [63:0] data);
    int l = lat(d);
    adr[d] = a; drv[d] = data; drv_en[d] = 1'b1; wr[d] = 1'b1;
    @(posedge clk);
    for (int j = 0; j <= l; j++) begin
      @(negedge clk);
      if (j == 0) adr[d] = 16'($urandom);
      check_eq($sformatf("wr d%0d a%h done j%0d", d, a, j), 64'(done[d]), 64'(j == l));
      check_eq($sformatf("wr d%0d rdy j%0d", d, j), 64'(rdy[d]), 64'd0);
      check_eq($sformatf("wr d%0d busy j%0d", d, j), 64'(busy[d]), 64'd1);
      if (j == l) begin
        wr[d] = 1'b0; drv_en[d] = 1'b0;
      end
    end
    model_write(d, a, data);
    exp_writes[d]++;
    @(negedge clk);
    check_idle_counts(d, "wr");
  endtask

  task automatic do_read(input int d, input logic [15:0] a, input bit hold, input bit also_wr);
    int l = lat(d);
    logic [63:0] exp;
    exp_q.push_back(model_block(d, a));
    adr[d] = a; rd[d] = 1'b1;
    if (also_wr) wr[d] = 1'b1;
    @(posedge clk);
    for (int j = 0; j <= l; j++) begin
      @(negedge clk);
      if (j == 0) adr[d] = 16'($urandom);
      check_eq($sformatf("rd d%0d a%h rdy j%0d", d, a, j), 64'(rdy[d]), 64'(j == l));
      check_eq($sformatf("rd d%0d done j%0d", d, j), 64'(done[d]), 64'd0);
      check_eq($sformatf("rd d%0d busy j%0d", d, j), 64'(busy[d]), 64'd1);
      if (j == l) begin
        exp = exp_q.pop_front();
        check_eq($sformatf("rd d%0d a%h data", d, a), get_dm(d), exp);
        if (!hold) rd[d] = 1'b0;
      end
    end
    exp_reads[d]++;
    @(negedge clk);
    check_idle_counts(d, "rd");
  endtask

  task automatic check_bus_free(input int d);
    logic [63:0] pat;
    pat = {$urandom, $urandom};
    drv[d] = pat; drv_en[d] = 1'b1;
    #1;
    check_eq($sformatf("bus free d%0d", d), get_dm(d), pat);
    drv_en[d] = 1'b0;
  endtask

  initial begin
    logic [15:0] a;
    logic [63:0] data;
    int d;

    reset = 1'b1;
    rd = '0; wr = '0; drv_en = '0;
    for (int i = 0; i < 2; i++) begin
      adr[i] = '0; drv[i] = '0; exp_reads[i] = 0; exp_writes[i] = 0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("reset d%0d rdy", i), 64'(rdy[i]), 64'd0);
      check_eq($sformatf("reset d%0d done", i), 64'(done[i]), 64'd0);
      check_idle_counts(i, "reset");
      check_bus_free(i);
    end

    // Fill both memories so every later read has a known expectation.
    for (int b = 0; b < 64; b++)
      do_write(0, {8'($urandom), 6'(b), 2'($urandom)}, {$urandom, $urandom});
    for (int w = 0; w < 256; w++)
      do_write(1, {8'($urandom), 8'(w)}, {$urandom, $urandom});

    // Preloaded block read.
    do_write(0, 16'h0010, 64'h00A3_00A2_00A1_00A0);
    do_read(0, 16'h0012, 1'b0, 1'b0);
    // Full-block write then read from another word of the same block.
    do_write(0, 16'h0020, 64'h4444_3333_2222_1111);
    do_read(0, 16'h0021, 1'b0, 1'b0);
    // Single-word write lands only in word 0x22.
    do_write(1, 16'h0022, {$urandom, 16'h1234, 16'hBEEF});
    do_read(1, 16'h0020, 1'b0, 1'b0);
    // Simultaneous read and write: read first, write after the idle gap.
    do_read(0, 16'h0044, 1'b0, 1'b1);
    do_write(0, 16'h0048, {$urandom, $urandom});
    // Upper address bits alias.
    do_write(0, 16'hFFFC, {$urandom, $urandom});
    do_read(0, 16'h00FE, 1'b0, 1'b0);

    // Reset two cycles into a write: no commit, counters cleared.
    adr[0] = 16'h0030; drv[0] = 64'hDEAD_BEEF_CAFE_F00D; drv_en[0] = 1'b1; wr[0] = 1'b1;
    @(posedge clk);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0; wr[0] = 1'b0; drv_en[0] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      exp_reads[i] = 0; exp_writes[i] = 0;
    end
    for (int j = 0; j < 6; j++) begin
      check_eq($sformatf("abort done j%0d", j), 64'(done[0]), 64'd0);
      check_eq($sformatf("abort rdy j%0d", j), 64'(rdy[0]), 64'd0);
      @(negedge clk);
    end
    for (int i = 0; i < 2; i++) begin
      check_idle_counts(i, "abort");
      check_bus_free(i);
    end
    do_read(0, 16'h0030, 1'b0, 1'b0);

    // Back-to-back held reads at LATENCY=1.
    for (int k = 0; k < 5; k++)
      do_read(1, 16'($urandom), (k != 4), 1'b0);

    // Random traffic.
    for (int n = 0; n < 200; n++) begin
      d = int'($urandom_range(0, 1));
      a = 16'($urandom);
      data = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 0) do_write(d, a, data);
      else do_read(d, a, 1'b0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
